// File: rtl/aes_roundtrip_sequencer.sv
// Self-test sequencer: walks NUM_VEC ROM vectors through the encrypt and decrypt masters and scores each round trip.
// Optional macro AES_RTS_KAT_CHECK_EN adds a known-answer check of the returned ciphertext against vec_ct.
module aes_roundtrip_sequencer #(
    parameter int NK      = 6,
    parameter int NUM_VEC = 3,
    parameter int TIMEOUT = 20000,
    parameter int IDX_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] vec_idx,
    input  logic [127:0]     vec_msg,
    input  logic [32*NK-1:0] vec_key,
    input  logic [127:0]     vec_ct,
    output logic [127:0]     enc_msg,
    output logic [32*NK-1:0] enc_key,
    output logic             enc_req,
    input  logic             enc_done,
    input  logic [127:0]     enc_ct,
    output logic [127:0]     dec_msg,
    output logic             dec_req,
    input  logic             dec_done,
    input  logic [127:0]     dec_pt,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   pass_cnt,
    output logic [IDX_W:0]   fail_cnt,
    output logic [IDX_W:0]   tmo_cnt
);
    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ENC_REQ,
        S_ENC_WAIT,
        S_DEC_REQ,
        S_DEC_WAIT,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IDX_W-1:0] r_vec_idx;
    logic             r_load_wait;
    logic [127:0]     r_pt;
    logic [32*NK-1:0] r_key;
    logic [127:0]     r_enc_ct;
    logic [127:0]     r_dec_pt;
    logic [TMR_W-1:0] r_timer;
    logic [IDX_W:0]   r_pass_cnt;
    logic [IDX_W:0]   r_fail_cnt;
    logic [IDX_W:0]   r_tmo_cnt;

    logic w_clear_run;
    logic w_capture_rom;
    logic w_load_timer;
    logic w_enc_capture;
    logic w_dec_capture;
    logic w_tmo;
    logic w_pass;
    logic w_fail_chk;
    logic w_idx_inc;
    logic w_in_wait;
    logic w_tmr_last;
    logic w_rt_ok;
    logic w_kat_ok;
    logic [3:0] w_lane_eq;

    assign w_in_wait  = (r_state == S_ENC_WAIT) || (r_state == S_DEC_WAIT);
    assign w_tmr_last = (r_timer == TMR_LAST);

    // Round-trip compare split into 32-bit lanes to keep the comparator shallow.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_eq[gi] = (r_dec_pt[32*gi +: 32] == r_pt[32*gi +: 32]);
        end
    endgenerate
    assign w_rt_ok = &w_lane_eq;

`ifdef AES_RTS_KAT_CHECK_EN
    logic [127:0] r_ct_exp;
    logic         r_kat_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ct_exp  <= '0;
            r_kat_err <= 1'b0;
        end else begin
            if (w_capture_rom) begin
                r_ct_exp  <= vec_ct;
                r_kat_err <= 1'b0;
            end
            if (w_enc_capture) begin
                r_kat_err <= (enc_ct != r_ct_exp);
            end
        end
    end
    assign w_kat_ok = ~r_kat_err;
`else
    // vec_ct is kept on the port list only for interface stability.
    logic w_unused_vec_ct;
    assign w_unused_vec_ct = ^vec_ct;
    assign w_kat_ok        = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_clear_run   = 1'b0;
        w_capture_rom = 1'b0;
        w_load_timer  = 1'b0;
        w_enc_capture = 1'b0;
        w_dec_capture = 1'b0;
        w_tmo         = 1'b0;
        w_pass        = 1'b0;
        w_fail_chk    = 1'b0;
        w_idx_inc     = 1'b0;
        enc_req       = 1'b0;
        dec_req       = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_clear_run  = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_load_wait) begin
                    w_capture_rom = 1'b1;
                    w_state_next  = S_ENC_REQ;
                end
            end
            S_ENC_REQ: begin
                enc_req      = 1'b1;
                w_load_timer = 1'b1;
                w_state_next = S_ENC_WAIT;
            end
            S_ENC_WAIT: begin
                // A done pulse in the final timer cycle still counts.
                if (enc_done) begin
                    w_enc_capture = 1'b1;
                    w_state_next  = S_DEC_REQ;
                end else if (w_tmr_last) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_NEXT;
                end
            end
            S_DEC_REQ: begin
                dec_req      = 1'b1;
                w_load_timer = 1'b1;
                w_state_next = S_DEC_WAIT;
            end
            S_DEC_WAIT: begin
                if (dec_done) begin
                    w_dec_capture = 1'b1;
                    w_state_next  = S_CHECK;
                end else if (w_tmr_last) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_NEXT;
                end
            end
            S_CHECK: begin
                if (w_rt_ok && w_kat_ok) begin
                    w_pass = 1'b1;
                end else begin
                    w_fail_chk = 1'b1;
                end
                w_state_next = S_NEXT;
            end
            S_NEXT: begin
                if (r_vec_idx == LAST_IDX) begin
                    w_state_next = S_DONE;
                end else begin
                    w_idx_inc    = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_DONE: begin
                busy         = 1'b0;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_idx   <= '0;
            r_load_wait <= 1'b0;
            r_pt        <= '0;
            r_key       <= '0;
            r_enc_ct    <= '0;
            r_dec_pt    <= '0;
            r_timer     <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            // LOAD spends one cycle letting the ROM settle, then captures on the second.
            r_load_wait <= (r_state == S_LOAD) && !r_load_wait;

            if (w_clear_run) begin
                r_vec_idx <= '0;
            end else if (w_idx_inc) begin
                r_vec_idx <= r_vec_idx + 1'b1;
            end

            if (w_capture_rom) begin
                r_pt  <= vec_msg;
                r_key <= vec_key;
            end

            if (w_load_timer) begin
                r_timer <= TMR_LOAD;
            end else if (w_in_wait) begin
                r_timer <= r_timer - 1'b1;
            end

            if (w_enc_capture) begin
                r_enc_ct <= enc_ct;
            end
            if (w_dec_capture) begin
                r_dec_pt <= dec_pt;
            end

            if (w_clear_run) begin
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_tmo_cnt  <= '0;
            end else begin
                if (w_pass) begin
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                end
                if (w_fail_chk || w_tmo) begin
                    r_fail_cnt <= r_fail_cnt + 1'b1;
                end
                if (w_tmo) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
        end
    end

    assign vec_idx  = r_vec_idx;
    assign enc_msg  = r_pt;
    assign enc_key  = r_key;
    assign dec_msg  = r_enc_ct;
    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;
    assign tmo_cnt  = r_tmo_cnt;

endmodule

// File: tb/tb_aes_roundtrip_sequencer.sv
// Bench for aes_roundtrip_sequencer: ROM and master models plus a per-run outcome/latency reference model.
// Honours AES_RTS_KAT_CHECK_EN the same way the design does.
module tb_aes_roundtrip_sequencer;
    localparam int NK      = 6;
    localparam int KW      = 32 * NK;
    localparam int NUM_VEC = 4;
    localparam int TIMEOUT = 16;
    localparam int IDX_W   = 8;
    localparam int NEVER   = -1;
`ifdef AES_RTS_KAT_CHECK_EN
    localparam bit KAT_EN = 1'b1;
`else
    localparam bit KAT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [IDX_W-1:0] vec_idx;
    logic [127:0]     vec_msg = '0;
    logic [KW-1:0]    vec_key = '0;
    logic [127:0]     vec_ct  = '0;
    logic [127:0]     enc_msg;
    logic [KW-1:0]    enc_key;
    logic             enc_req;
    logic             enc_done;
    logic [127:0]     enc_ct;
    logic [127:0]     dec_msg;
    logic             dec_req;
    logic             dec_done;
    logic [127:0]     dec_pt;
    logic             busy;
    logic             done;
    logic [IDX_W:0]   pass_cnt;
    logic [IDX_W:0]   fail_cnt;
    logic [IDX_W:0]   tmo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_roundtrip_sequencer #(
        .NK(NK), .NUM_VEC(NUM_VEC), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vec_idx(vec_idx),
        .vec_msg(vec_msg), .vec_key(vec_key), .vec_ct(vec_ct),
        .enc_msg(enc_msg), .enc_key(enc_key), .enc_req(enc_req),
        .enc_done(enc_done), .enc_ct(enc_ct), .dec_msg(dec_msg),
        .dec_req(dec_req), .dec_done(dec_done), .dec_pt(dec_pt),
        .busy(busy), .done(done), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt)
    );

    // Vector store and per-vector master behaviour.
    logic [127:0] rom_msg [NUM_VEC];
    logic [KW-1:0] rom_key [NUM_VEC];
    logic [127:0] rom_ct  [NUM_VEC];
    int enc_dly [NUM_VEC];
    int dec_dly [NUM_VEC];
    bit ct_flip [NUM_VEC];
    bit pt_flip [NUM_VEC];

    always @(posedge clk) begin
        vec_msg <= rom_msg[int'(vec_idx) % NUM_VEC];
        vec_key <= rom_key[int'(vec_idx) % NUM_VEC];
        vec_ct  <= rom_ct[int'(vec_idx) % NUM_VEC];
    end

    logic         m_enc_done = 1'b0, x_enc_done = 1'b0;
    logic         m_dec_done = 1'b0, x_dec_done = 1'b0;
    logic [127:0] m_enc_ct = '0, m_dec_pt = '0;
    assign enc_done = m_enc_done | x_enc_done;
    assign dec_done = m_dec_done | x_dec_done;
    assign enc_ct   = m_enc_ct;
    assign dec_pt   = m_dec_pt;

    // Encrypt master: returns the table ciphertext only for the right plaintext/key.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (enc_req === 1'b1) begin
                int k;
                int d;
                k = int'(vec_idx) % NUM_VEC;
                d = enc_dly[k];
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                    if (enc_msg == rom_msg[k] && enc_key == rom_key[k])
                        m_enc_ct = rom_ct[k] ^ {127'b0, ct_flip[k]};
                    else
                        m_enc_ct = ~rom_ct[k];
                    m_enc_done = 1'b1;
                    @(posedge clk);
                    #1;
                    m_enc_done = 1'b0;
                end
            end
        end
    end

    // Decrypt master: recovers the plaintext only from the ciphertext encrypt handed out, under the same key.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (dec_req === 1'b1) begin
                int k;
                int d;
                k = int'(vec_idx) % NUM_VEC;
                d = dec_dly[k];
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                    if (dec_msg == (rom_ct[k] ^ {127'b0, ct_flip[k]}) && enc_key == rom_key[k])
                        m_dec_pt = rom_msg[k] ^ {127'b0, pt_flip[k]};
                    else
                        m_dec_pt = ~rom_msg[k];
                    m_dec_done = 1'b1;
                    @(posedge clk);
                    #1;
                    m_dec_done = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_rom_random();
        for (int v = 1; v < NUM_VEC; v++) begin
            logic [KW-1:0] k;
            for (int w = 0; w < NK; w++) k[32*w +: 32] = $urandom;
            rom_key[v] = k;
            rom_msg[v] = rand128();
            rom_ct[v]  = rand128();
        end
    endtask

    task automatic set_clean(input int d);
        for (int v = 0; v < NUM_VEC; v++) begin
            enc_dly[v] = d; dec_dly[v] = d; ct_flip[v] = 1'b0; pt_flip[v] = 1'b0;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_vec_idx"}, 256'(vec_idx), 256'(0));
        check_eq({tag, "_enc_msg"}, 256'(enc_msg), 256'(0));
        check_eq({tag, "_enc_key"}, 256'(enc_key), 256'(0));
        check_eq({tag, "_dec_msg"}, 256'(dec_msg), 256'(0));
        check_eq({tag, "_cnts"}, 256'({pass_cnt, fail_cnt, tmo_cnt}), 256'(0));
        check_eq({tag, "_ctl"}, 256'({busy, done, enc_req, dec_req}), 256'(0));
    endtask

    // One complete run: predict outcome and timing from the vector rules, then observe.
    task automatic run_and_check(input string tag, input bit poke_start);
        int exp_pass = 0, exp_fail = 0, exp_tmo = 0, exp_cyc = 0, exp_decreq = 0;
        int cyc = 0, busy_cyc = 0, n_done = 0, done_cyc = 0, n_encreq = 0, n_decreq = 0;
        int idx_q[$];
        for (int v = 0; v < NUM_VEC; v++) begin
            if (enc_dly[v] < 1 || enc_dly[v] > TIMEOUT) begin
                exp_tmo++; exp_fail++; exp_cyc += 2 + 1 + TIMEOUT + 1;
            end else begin
                exp_decreq++;
                if (dec_dly[v] < 1 || dec_dly[v] > TIMEOUT) begin
                    exp_tmo++; exp_fail++; exp_cyc += 2 + 1 + enc_dly[v] + 1 + TIMEOUT + 1;
                end else begin
                    exp_cyc += 2 + 1 + enc_dly[v] + 1 + dec_dly[v] + 1 + 1;
                    if (pt_flip[v] || (KAT_EN && ct_flip[v])) exp_fail++;
                    else exp_pass++;
                end
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n_done == 0 && cyc < 4000) begin
            cyc++;
            if (busy) busy_cyc++;
            if (enc_req) n_encreq++;
            if (dec_req) n_decreq++;
            if (busy && (idx_q.size() == 0 || idx_q[$] != int'(vec_idx))) idx_q.push_back(int'(vec_idx));
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check_eq({tag, "_pass_cnt"}, 256'(pass_cnt), 256'(exp_pass));
                check_eq({tag, "_fail_cnt"}, 256'(fail_cnt), 256'(exp_fail));
                check_eq({tag, "_tmo_cnt"}, 256'(tmo_cnt), 256'(exp_tmo));
                check_eq({tag, "_cnt_sum"}, 256'(pass_cnt + fail_cnt), 256'(NUM_VEC));
            end else begin
                start = (poke_start && busy && (cyc % 5 == 2)) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, 256'(n_done), 256'(1));
        check_eq({tag, "_done_cycle"}, 256'(done_cyc), 256'(exp_cyc + 1));
        check_eq({tag, "_busy_cycles"}, 256'(busy_cyc), 256'(exp_cyc));
        check_eq({tag, "_enc_reqs"}, 256'(n_encreq), 256'(NUM_VEC));
        check_eq({tag, "_dec_reqs"}, 256'(n_decreq), 256'(exp_decreq));
        check_eq({tag, "_idx_count"}, 256'(idx_q.size()), 256'(NUM_VEC));
        for (int i = 0; i < idx_q.size() && i < NUM_VEC; i++)
            check_eq($sformatf("%s_idx_seq%0d", tag, i), 256'(idx_q[i]), 256'(i));
        repeat (3) begin
            @(negedge clk);
            check_eq({tag, "_post_ctl"}, 256'({busy, done}), 256'(0));
        end
        check_eq({tag, "_hold_cnts"}, 256'({pass_cnt, fail_cnt, tmo_cnt}),
                 256'({9'(exp_pass), 9'(exp_fail), 9'(exp_tmo)}));
        $display("run %s vectors=%0d good=%0d bad=%0d timeouts=%0d cycles=%0d",
                 tag, NUM_VEC, pass_cnt, fail_cnt, tmo_cnt, busy_cyc);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rom_key[0] = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        rom_msg[0] = 128'h00112233445566778899aabbccddeeff;
        rom_ct[0]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        fill_rom_random();
        set_clean(2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset");

        // Clean round trips, FIPS-197 AES-192 vector first.
        set_clean(2);
        enc_dly[1] = 1; dec_dly[2] = 3;
        run_and_check("clean", 1'b0);

        // Stray done pulses while idle must leave the held result alone.
        @(negedge clk);
        x_enc_done = 1'b1; x_dec_done = 1'b1;
        @(negedge clk);
        x_enc_done = 1'b0; x_dec_done = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_done_cnts", 256'({pass_cnt, fail_cnt, tmo_cnt}), 256'({9'(NUM_VEC), 9'(0), 9'(0)}));
        check_eq("idle_done_busy", 256'(busy), 256'(0));

        // Boundaries: done on the last timer cycle, KAT mismatch, decrypt and encrypt timeouts.
        set_clean(3);
        enc_dly[0] = TIMEOUT; dec_dly[0] = TIMEOUT;
        ct_flip[1] = 1'b1;
        dec_dly[2] = NEVER;
        enc_dly[3] = NEVER;
        run_and_check("boundary", 1'b1);

        // Reset in the middle of ENC_WAIT.
        set_clean(10);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int w = 0;
            while (enc_req !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            check_eq("rst_enc_req_seen", 256'(enc_req), 256'(1));
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("midrst");
        repeat (20) @(negedge clk);
        check_eq("midrst_idle_busy", 256'(busy), 256'(0));
        check_eq("midrst_idle_cnts", 256'({pass_cnt, fail_cnt, tmo_cnt}), 256'(0));
        set_clean(4);
        run_and_check("rerun", 1'b0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            fill_rom_random();
            for (int v = 0; v < NUM_VEC; v++) begin
                enc_dly[v] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, TIMEOUT));
                dec_dly[v] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, TIMEOUT));
                ct_flip[v] = ($urandom_range(0, 3) == 0);
                pt_flip[v] = ($urandom_range(0, 4) == 0);
            end
            run_and_check($sformatf("rand%0d", r), r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
